out_bcd: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/out_bcd_if.sv | 15 +
 rtl/out_bcd_digit_adj.sv | 10 +
 rtl/out_bcd.sv | 99 +++++++++
 tb/tb_out_bcd.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the CPU core and its downstream stages.
// Holds the out_bcd FSM encodings and the double-dabble digit constants.
package cpu_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADD3_THRESH = 4'd5;

    localparam logic [1:0] OUT_BCD_IDLE  = 2'd0;
    localparam logic [1:0] OUT_BCD_SHIFT = 2'd1;
    localparam logic [1:0] OUT_BCD_DONE  = 2'd2;

    // Largest decimal range (10**n) a digit count can represent, for sizing checks.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/out_bcd_if.sv
// Bus between the CPU output register and the BCD display converter.
// master = producer of the binary word, slave = the converter.
interface out_bcd_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
);
    logic [DATA_WIDTH-1:0] in;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  busy;
    logic                  done;

    modport master (output in, input bcd, neg, busy, done);
    modport slave  (input in, output bcd, neg, busy, done);
endinterface

// File: rtl/out_bcd_digit_adj.sv
// One double-dabble digit correction: digits of 5 or more get 3 added
// before the shift so they carry correctly into the next decimal place.
module bcd_digit_adj
    import cpu_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = (d >= BCD_ADD3_THRESH) ? d + 4'd3 : d;
endmodule

// File: rtl/out_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Define OUT_BCD_SIGNED_EN to treat the input as two's complement.
module out_bcd
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    out_bcd_if.slave  bus
);
    localparam int WORK_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);

    if (pow10(DIGITS) < (longint'(1) << DATA_WIDTH)) begin : g_digits_too_few
        $error("out_bcd: DIGITS too small for DATA_WIDTH");
    end

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] last;
    logic [DATA_WIDTH-1:0] sh;
    logic [WORK_W-1:0]     work;
    logic [WORK_W-1:0]     work_adj;
    logic [CNT_W-1:0]      cnt;
    logic                  sign_q;
    logic [WORK_W-1:0]     bcd_q;
    logic                  neg_q;
    logic                  done_q;

    logic                  in_sign;
    logic [DATA_WIDTH-1:0] in_mag;
    logic [WORK_W+DATA_WIDTH-1:0] shifted;

`ifdef OUT_BCD_SIGNED_EN
    // Negating the most negative value wraps to itself, which read unsigned is its magnitude.
    assign in_sign = bus.in[DATA_WIDTH-1];
    assign in_mag  = in_sign ? (~bus.in + 1'b1) : bus.in;
`else
    assign in_sign = 1'b0;
    assign in_mag  = bus.in;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shifted = {work_adj, sh} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OUT_BCD_IDLE;
            last   <= '0;
            sh     <= '0;
            work   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            bcd_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                OUT_BCD_IDLE: begin
                    if (bus.in != last) begin
                        last   <= bus.in;
                        sh     <= in_mag;
                        sign_q <= in_sign;
                        work   <= '0;
                        cnt    <= CNT_W'(DATA_WIDTH);
                        state  <= OUT_BCD_SHIFT;
                    end
                end
                OUT_BCD_SHIFT: begin
                    work <= shifted[WORK_W+DATA_WIDTH-1:DATA_WIDTH];
                    sh   <= shifted[DATA_WIDTH-1:0];
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= OUT_BCD_DONE;
                end
                OUT_BCD_DONE: begin
                    bcd_q  <= work;
                    neg_q  <= sign_q;
                    done_q <= 1'b1;
                    state  <= OUT_BCD_IDLE;
                end
                default: state <= OUT_BCD_IDLE;
            endcase
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.neg  = neg_q;
    assign bus.done = done_q;
    assign bus.busy = (state != OUT_BCD_IDLE);

endmodule

// File: tb/tb_out_bcd.sv
// Self-checking bench for out_bcd against a decimal-arithmetic reference model.
// Honours OUT_BCD_SIGNED_EN the same way as the design.
module tb_out_bcd;
    localparam int W = 16;
    localparam int D = 5;
    localparam int EXP_EDGES = W + 2;
    localparam int EXP_BUSY  = W + 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    out_bcd_if #(.DATA_WIDTH(W), .DIGITS(D)) bus ();

    out_bcd #(.DATA_WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*D-1:0] model_bcd(input logic [W-1:0] v);
        int unsigned m;
        logic [4*D-1:0] r;
        m = int'(v);
`ifdef OUT_BCD_SIGNED_EN
        if (v[W-1]) m = 32'd65536 - int'(v);
`endif
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic model_neg(input logic [W-1:0] v);
`ifdef OUT_BCD_SIGNED_EN
        return v[W-1];
`else
        return 1'b0;
`endif
    endfunction

    // Counts edges from the sampling edge until done, bounded so a dead DUT cannot hang the run.
    task automatic wait_done(output int edges, output int busy_hi, output bit ok);
        edges = 0; busy_hi = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done) begin ok = 1'b1; break; end
            if (bus.busy) busy_hi++;
        end
    endtask

    task automatic convert_and_check(input logic [W-1:0] v, input string name);
        int edges, busy_hi;
        bit ok;
        @(negedge clk);
        bus.in = v;
        wait_done(edges, busy_hi, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL %s timeout: no done within 100 cycles", name);
        else n_pass++;
        n_checks++;
        if (edges !== EXP_EDGES) $display("[TB] FAIL %s latency: got %0d edges, want %0d", name, edges, EXP_EDGES);
        else n_pass++;
        n_checks++;
        if (bus.bcd !== model_bcd(v)) $display("[TB] FAIL %s bcd: got %h, want %h", name, bus.bcd, model_bcd(v));
        else n_pass++;
        n_checks++;
        if (bus.neg !== model_neg(v)) $display("[TB] FAIL %s neg: got %b, want %b", name, bus.neg, model_neg(v));
        else n_pass++;
    endtask

    task automatic test_reset();
        int done_cnt, busy_cnt;
        rst_n = 1'b0;
        bus.in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.bcd !== 20'h00000 || bus.neg !== 1'b0) $display("[TB] FAIL reset_vals: bcd=%h neg=%b, want 00000/0", bus.bcd, bus.neg);
        else n_pass++;
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0 || busy_cnt !== 0) $display("[TB] FAIL reset_idle: done=%0d busy=%0d cycles, want 0/0", done_cnt, busy_cnt);
        else n_pass++;
    endtask

    task automatic test_single();
        int edges, busy_hi;
        bit ok;
        logic [4*D-1:0] held;
        @(negedge clk);
        bus.in = 16'd1234;
        wait_done(edges, busy_hi, ok);
        n_checks++;
        if (!ok || edges !== EXP_EDGES) $display("[TB] FAIL single_latency: ok=%b edges=%0d, want 1/%0d", ok, edges, EXP_EDGES);
        else n_pass++;
        n_checks++;
        if (busy_hi !== EXP_BUSY) $display("[TB] FAIL single_busy: got %0d busy samples, want %0d", busy_hi, EXP_BUSY);
        else n_pass++;
        n_checks++;
        if (bus.bcd !== 20'h01234) $display("[TB] FAIL single_bcd: got %h, want 01234", bus.bcd);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL single_busy_at_done: got %b, want 0", bus.busy);
        else n_pass++;
        held = bus.bcd;
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL single_done_width: got %b one cycle later, want 0", bus.done);
        else n_pass++;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (bus.bcd !== 20'h01234 || bus.busy !== 1'b0) $display("[TB] FAIL single_hold: bcd=%h busy=%b, want 01234/0", bus.bcd, bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.bcd !== held) $display("[TB] FAIL single_stable: got %h, want %h", bus.bcd, held);
        else n_pass++;
    endtask

    task automatic test_extremes();
        convert_and_check(16'd65535, "max");
        convert_and_check(16'd9, "nine");
    endtask

    task automatic test_no_change();
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt !== 0) $display("[TB] FAIL no_change: %0d busy/done cycles with steady input, want 0", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        logic [4*D-1:0] seen [2];
        done_cnt = 0;
        seen[0] = '0; seen[1] = '0;
        @(negedge clk);
        bus.in = 16'd100;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (i == 4) bus.in = 16'd200;
            if (bus.done) begin
                if (done_cnt < 2) seen[done_cnt] = bus.bcd;
                done_cnt++;
            end
        end
        n_checks++;
        if (done_cnt !== 2) $display("[TB] FAIL b2b_pulses: got %0d, want 2", done_cnt);
        else n_pass++;
        n_checks++;
        if (seen[0] !== model_bcd(16'd100)) $display("[TB] FAIL b2b_first: got %h, want %h", seen[0], model_bcd(16'd100));
        else n_pass++;
        n_checks++;
        if (seen[1] !== model_bcd(16'd200)) $display("[TB] FAIL b2b_second: got %h, want %h", seen[1], model_bcd(16'd200));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int edges, busy_hi, done_cnt;
        bit ok;
        done_cnt = 0;
        @(negedge clk);
        bus.in = 16'd4321;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.bcd !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.neg !== 1'b0)
            $display("[TB] FAIL midreset_vals: bcd=%h busy=%b done=%b neg=%b, want 0/0/0/0", bus.bcd, bus.busy, bus.done, bus.neg);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 0) $display("[TB] FAIL midreset_early_done: got %0d pulses, want 0", done_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(edges, busy_hi, ok);
        n_checks++;
        if (!ok || edges !== EXP_EDGES) $display("[TB] FAIL midreset_restart: ok=%b edges=%0d, want 1/%0d", ok, edges, EXP_EDGES);
        else n_pass++;
        n_checks++;
        if (bus.bcd !== 20'h04321) $display("[TB] FAIL midreset_bcd: got %h, want 04321", bus.bcd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] prev, v;
        prev = bus.in;
        for (int i = 0; i < 20; i++) begin
            v = W'($urandom_range(0, 65535));
            if (v == prev) v = v + 1'b1;
            convert_and_check(v, "random");
            prev = v;
        end
    endtask

`ifdef OUT_BCD_SIGNED_EN
    task automatic test_signed();
        convert_and_check(16'hFFFF, "minus_one");
        n_checks++;
        if (bus.bcd !== 20'h00001 || bus.neg !== 1'b1) $display("[TB] FAIL signed_ffff: bcd=%h neg=%b, want 00001/1", bus.bcd, bus.neg);
        else n_pass++;
        convert_and_check(16'h8000, "most_negative");
        n_checks++;
        if (bus.bcd !== 20'h32768 || bus.neg !== 1'b1) $display("[TB] FAIL signed_8000: bcd=%h neg=%b, want 32768/1", bus.bcd, bus.neg);
        else n_pass++;
        convert_and_check(16'd7, "positive");
        n_checks++;
        if (bus.bcd !== 20'h00007 || bus.neg !== 1'b0) $display("[TB] FAIL signed_7: bcd=%h neg=%b, want 00007/0", bus.bcd, bus.neg);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single();
        test_extremes();
        test_no_change();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef OUT_BCD_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
